// File: rtl/rtc_access_seq.sv
// Register-access sequencer for the RTC bus: validates a request, opens the select
// window and drives timed read/write strobes, then pulses done with an error status.
module rtc_access_seq #(
   parameter int unsigned ADDR_W       = 8,
   parameter int unsigned ADDR_MIN     = 5,
   parameter int unsigned ADDR_MAX     = 7,
   parameter int unsigned SETUP_CYCLES = 1,
   parameter int unsigned RD_CYCLES    = 257,
   parameter int unsigned GAP_CYCLES   = 1,
   parameter int unsigned WR_CYCLES    = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic              abort,
   output logic [ADDR_W-1:0] addr_out,
   output logic              sel,
   output logic              rd,
   output logic              wr,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned MAX_SR  = (SETUP_CYCLES > RD_CYCLES) ? SETUP_CYCLES : RD_CYCLES;
   localparam int unsigned MAX_GW  = (GAP_CYCLES > WR_CYCLES) ? GAP_CYCLES : WR_CYCLES;
   localparam int unsigned MAX_LEN = (MAX_SR > MAX_GW) ? MAX_SR : MAX_GW;
   localparam int unsigned CNT_W   = $clog2(MAX_LEN) + 1;

   // Counter reload values: a phase of N cycles counts N-1 down to 0.
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LD    = CNT_W'(RD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] WR_LD    = CNT_W'(WR_CYCLES - 1);

   localparam logic [1:0] MODE_RD  = 2'b00;
   localparam logic [1:0] MODE_WR  = 2'b01;
   localparam logic [1:0] MODE_RMW = 2'b10;
   localparam logic [1:0] MODE_BAD = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_READ,
      S_GAP,
      S_WRITE,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        mode_q, mode_d;
   logic [ADDR_W-1:0] addr_d;
   logic              err_d;
   logic              sel_d, rd_d, wr_d, busy_d, done_d;
   logic              legal_c;

   assign legal_c = (addr_in >= ADDR_W'(ADDR_MIN)) && (addr_in <= ADDR_W'(ADDR_MAX))
                    && (mode != MODE_BAD);

   // Next-state, counter and next-output logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      addr_d  = addr_out;
      err_d   = err;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (legal_c) begin
                  state_d = S_SETUP;
                  cnt_d   = SETUP_LD;
                  mode_d  = mode;
                  addr_d  = addr_in;
                  err_d   = 1'b0;
               end else begin
                  state_d = S_DONE;
                  cnt_d   = '0;
                  err_d   = 1'b1;
               end
            end
         end
         S_SETUP: begin
            if (abort) begin
               state_d = S_DONE;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (mode_q == MODE_WR) begin
               state_d = S_WRITE;
               cnt_d   = WR_LD;
            end else begin
               state_d = S_READ;
               cnt_d   = RD_LD;
            end
         end
         S_READ: begin
            if (abort) begin
               state_d = S_DONE;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (mode_q == MODE_RMW) begin
               state_d = S_GAP;
               cnt_d   = GAP_LD;
            end else begin
               state_d = S_DONE;
               cnt_d   = '0;
            end
         end
         S_GAP: begin
            if (abort) begin
               state_d = S_DONE;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = S_WRITE;
               cnt_d   = WR_LD;
            end
         end
         S_WRITE: begin
            if (abort) begin
               state_d = S_DONE;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = S_DONE;
               cnt_d   = '0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Outputs are decoded from the next state so they register in step with it
      sel_d  = (state_d == S_SETUP) || (state_d == S_READ) ||
               (state_d == S_GAP)   || (state_d == S_WRITE);
      rd_d   = (state_d == S_READ);
      wr_d   = (state_d == S_WRITE);
      busy_d = sel_d;
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         mode_q   <= MODE_RD;
         addr_out <= '0;
         err      <= 1'b0;
         sel      <= 1'b0;
         rd       <= 1'b0;
         wr       <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         addr_out <= addr_d;
         err      <= err_d;
         sel      <= sel_d;
         rd       <= rd_d;
         wr       <= wr_d;
         busy     <= busy_d;
         done     <= done_d;
      end
   end

endmodule

// File: tb/tb_rtc_access_seq.sv
// Directed bench for rtc_access_seq: default-parameter instance plus a
// one-cycle-phase instance, checked against hand-computed cycle numbers.
module tb_rtc_access_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       start, start1, abort;
   logic [1:0] mode;
   logic [7:0] addr_in;
   logic [7:0] addr_out, addr_out1;
   logic       sel, rd, wr, busy, done, err;
   logic       sel1, rd1, wr1, busy1, done1, err1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rtc_access_seq dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .addr_in(addr_in),
      .abort(abort), .addr_out(addr_out), .sel(sel), .rd(rd), .wr(wr),
      .busy(busy), .done(done), .err(err)
   );

   rtc_access_seq #(
      .SETUP_CYCLES(1), .RD_CYCLES(1), .GAP_CYCLES(1), .WR_CYCLES(1)
   ) dut1 (
      .clk(clk), .reset(reset), .start(start1), .mode(mode), .addr_in(addr_in),
      .abort(abort), .addr_out(addr_out1), .sel(sel1), .rd(rd1), .wr(wr1),
      .busy(busy1), .done(done1), .err(err1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Issue one request and observe the default instance cycle by cycle until done.
   // Cycle 1 is the cycle after the edge that samples start.
   task automatic txn(input logic [1:0] m, input logic [7:0] a,
                      input int abort_at, input int start_at,
                      output int done_cyc, output int rd_n, output int wr_n,
                      output int sel_n, output int rd_first, output int wr_first,
                      output int bad, output logic err_done);
      int cyc;
      done_cyc = -1; rd_n = 0; wr_n = 0; sel_n = 0;
      rd_first = -1; wr_first = -1; bad = 0; err_done = 1'b0;
      @(negedge clk);
      start = 1'b1; mode = m; addr_in = a;
      @(negedge clk);
      start = 1'b0; mode = ~m; addr_in = a + 8'd1;
      cyc = 1;
      while (cyc < 2000 && done_cyc < 0) begin
         if (rd) begin rd_n++; if (rd_first < 0) rd_first = cyc; end
         if (wr) begin wr_n++; if (wr_first < 0) wr_first = cyc; end
         if (sel) sel_n++;
         if ((rd && wr) || (busy !== sel) || ((rd || wr) && !sel)) bad++;
         if (done) begin
            done_cyc = cyc;
            err_done = err;
         end else begin
            start = (cyc == start_at);
            abort = (cyc == abort_at);
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      abort = 1'b0;
      check("done_seen", 32'(done_cyc >= 0), 32'd1);
   endtask

   int   dc, rn, wn, sn, rf, wf, bd;
   logic ed;
   logic [7:0] bad_addr [0:2];
   logic [1:0] bad_mode [0:2];
   logic [3:0] exp1 [0:5];

   initial begin
      reset = 1'b1; start = 1'b0; start1 = 1'b0; abort = 1'b0;
      mode = 2'b00; addr_in = 8'd0;
      repeat (2) @(negedge clk);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_rd", 32'(rd), 32'd0);
      check("rst_wr", 32'(wr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_addr", 32'(addr_out), 32'd0);
      reset = 1'b0;

      // Read-modify-write at address 6
      txn(2'b10, 8'd6, -1, -1, dc, rn, wn, sn, rf, wf, bd, ed);
      check("rmw_done_cyc", dc, 516);
      check("rmw_rd_n", rn, 257);
      check("rmw_rd_first", rf, 2);
      check("rmw_wr_n", wn, 256);
      check("rmw_wr_first", wf, 260);
      check("rmw_sel_n", sn, 515);
      check("rmw_bad", bd, 0);
      check("rmw_err", 32'(ed), 32'd0);
      check("rmw_addr", 32'(addr_out), 32'd6);

      // Plain read at 5, plain write at 7
      txn(2'b00, 8'd5, -1, -1, dc, rn, wn, sn, rf, wf, bd, ed);
      check("rd_done_cyc", dc, 259);
      check("rd_rd_n", rn, 257);
      check("rd_wr_n", wn, 0);
      check("rd_sel_n", sn, 258);
      check("rd_addr", 32'(addr_out), 32'd5);
      txn(2'b01, 8'd7, -1, -1, dc, rn, wn, sn, rf, wf, bd, ed);
      check("wr_done_cyc", dc, 258);
      check("wr_wr_n", wn, 256);
      check("wr_wr_first", wf, 2);
      check("wr_rd_n", rn, 0);
      check("wr_err", 32'(ed), 32'd0);
      check("wr_addr", 32'(addr_out), 32'd7);

      // Illegal requests: address below/above range and mode 11
      bad_addr[0] = 8'd4; bad_mode[0] = 2'b00;
      bad_addr[1] = 8'd8; bad_mode[1] = 2'b01;
      bad_addr[2] = 8'd6; bad_mode[2] = 2'b11;
      for (int i = 0; i < 3; i++) begin
         txn(bad_mode[i], bad_addr[i], -1, -1, dc, rn, wn, sn, rf, wf, bd, ed);
         check($sformatf("ill%0d_done_cyc", i), dc, 1);
         check($sformatf("ill%0d_err", i), 32'(ed), 32'd1);
         check($sformatf("ill%0d_strobes", i), rn + wn + sn, 0);
         check($sformatf("ill%0d_addr", i), 32'(addr_out), 32'd7);
      end
      repeat (3) @(negedge clk);
      check("err_hold", 32'(err), 32'd1);

      // Abort sampled at edge 100 of an RMW, then a clean write
      txn(2'b10, 8'd6, 100, -1, dc, rn, wn, sn, rf, wf, bd, ed);
      check("abt_done_cyc", dc, 101);
      check("abt_rd_n", rn, 99);
      check("abt_sel_n", sn, 100);
      check("abt_wr_n", wn, 0);
      check("abt_err", 32'(ed), 32'd1);
      txn(2'b01, 8'd5, -1, -1, dc, rn, wn, sn, rf, wf, bd, ed);
      check("post_abt_done_cyc", dc, 258);
      check("post_abt_err", 32'(ed), 32'd0);

      // Illegal start pulse while busy must be ignored, and one during DONE too
      txn(2'b00, 8'd5, -1, 50, dc, rn, wn, sn, rf, wf, bd, ed);
      check("busy_start_done_cyc", dc, 259);
      check("busy_start_err", 32'(ed), 32'd0);
      check("busy_start_rd_n", rn, 257);
      start = 1'b1; mode = 2'b11; addr_in = 8'd6;
      @(negedge clk);
      start = 1'b0;
      check("done_start_done", 32'(done), 32'd0);
      @(negedge clk);
      check("done_start_done2", 32'(done), 32'd0);
      check("done_start_err", 32'(err), 32'd0);

      // Reset in the middle of a write
      start = 1'b1; mode = 2'b01; addr_in = 8'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (50) @(negedge clk);
      check("pre_rst_wr", 32'(wr), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_outs", 32'({sel, rd, wr, busy, done, err}), 32'd0);
      check("mid_rst_addr", 32'(addr_out), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      txn(2'b01, 8'd6, -1, -1, dc, rn, wn, sn, rf, wf, bd, ed);
      check("post_rst_done_cyc", dc, 258);
      check("post_rst_addr", 32'(addr_out), 32'd6);

      // Single-cycle phases: {sel,rd,wr,done} for cycles 1..6
      exp1[0] = 4'b1000; exp1[1] = 4'b1100; exp1[2] = 4'b1000;
      exp1[3] = 4'b1010; exp1[4] = 4'b0001; exp1[5] = 4'b0000;
      @(negedge clk);
      start1 = 1'b1; mode = 2'b10; addr_in = 8'd6;
      @(negedge clk);
      start1 = 1'b0; mode = 2'b00;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("small_c%0d", i + 1), 32'({sel1, rd1, wr1, done1}), 32'(exp1[i]));
         if (i == 4) check("small_err", 32'(err1), 32'd0);
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rtc_access_seq.md
# rtc_access_seq

Parametrised register-access sequencer for the RTC bus. On a start pulse it validates a target address, raises the bus select window, and drives timed read and/or write strobes whose lengths are set by parameters. It then reports completion with a done pulse and an error flag. It sits between the time-setting/control FSM and the RTC bus interface, and supports read, write and read-modify-write modes, abort, and address/mode validation.

## Interface
Parameters:
- ADDR_W, 8, address width
- ADDR_MIN, 5, lowest legal register address
- ADDR_MAX, 7, highest legal register address
- SETUP_CYCLES, 1, select-to-first-strobe cycles (≥1)
- RD_CYCLES, 257, rd high time in cycles (≥1)
- GAP_CYCLES, 1, rd-low-to-wr-high cycles in RMW (≥1)
- WR_CYCLES, 256, wr high time in cycles (≥1)
- CNT_W, derived, $clog2 of the largest phase length plus 1

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- mode  in  2  00 read, 01 write, 10 read-then-write, 11 illegal
- addr_in  in  ADDR_W  target register address
- abort  in  1  cancel request; sampled in SETUP/READ/GAP/WRITE
- addr_out  out  ADDR_W  latched address presented to the bus
- sel  out  1  access window (time-change strobe)
- rd  out  1  read strobe
- wr  out  1  write strobe
- busy  out  1  high from acceptance until DONE
- done  out  1  one-cycle completion pulse
- err  out  1  status of the last transaction

## Operation
- All outputs are registered. During reset, all outputs are 0 and the state is IDLE. Reset clears the state immediately, including mid-transaction.
- States: IDLE, SETUP, READ, GAP, WRITE, DONE. There is one shared phase counter, which reloads on every state entry.
- IDLE: if start=1 at an edge, the block checks the request. A legal request has ADDR_MIN ≤ addr_in ≤ ADDR_MAX (unsigned) and mode≠11.
  - Legal: go to SETUP. addr_out←addr_in, err←0.
  - Illegal: go to DONE with err←1. addr_out is unchanged, and no sel/rd/wr activity occurs.
- SETUP lasts SETUP_CYCLES cycles. The next state is READ for modes 00 and 10, and WRITE for mode 01.
- READ: rd=1 for RD_CYCLES. The next state is GAP for mode 10, and DONE for mode 00.
- GAP: rd=wr=0 for GAP_CYCLES, then go to WRITE.
- WRITE: wr=1 for WR_CYCLES, then go to DONE.
- DONE lasts exactly 1 cycle with done=1, busy=0, sel=rd=wr=0. The next state is IDLE.
- sel=1 and busy=1 throughout SETUP, READ, GAP and WRITE.
- rd and wr are never high in the same cycle.
- mode and addr_in are captured at acceptance. Later changes to them are ignored.
- abort=1 in SETUP, READ, GAP or WRITE moves the block to DONE at that edge, with err←1. rd, wr and sel are low from that edge on.
- abort has no effect in IDLE or DONE.
- start is ignored outside IDLE, including in DONE, so the minimum spacing between starts is 2 cycles.
- err holds its value until the next accepted start.

## Timing
- Edge 0 = the edge at which start is sampled in IDLE.
- Legal RMW request with default parameters:
  - SETUP in cycle 1
  - rd high in cycles 2..258
  - GAP in cycle 259
  - wr high in cycles 260..515
  - done in cycle 516
  - IDLE from cycle 517
- General total latency to done is 1+SETUP+RD+GAP+WR for RMW, 1+SETUP+RD for read, and 1+SETUP+WR for write.
- An illegal request produces done and err in cycle 1.
- Abort sampled at edge k produces done in cycle k+1; strobes are low from edge k.
- Phase counters count exactly N cycles for each parameter value N, including N=1.

## Test plan
- Reset, then RMW at addr 6 with defaults → addr_out=6; sel high for cycles 1..515; rd high for exactly 257 cycles; wr high for exactly 256 cycles with a 1-cycle gap; done=1 at cycle 516 with err=0.
- Read at addr 5 and write at addr 7 → rd high for 257 cycles with no wr; wr high for 256 cycles with no rd; done at cycles 259 and 258 respectively.
- addr 4, addr 8, and mode 11 at addr 6 → done=1 with err=1 at cycle 1; sel, rd and wr never rise; addr_out is unchanged.
- Abort at cycle 100 of an RMW → rd=0 and sel=0 from edge 100; done=1 and err=1 at cycle 101; a following legal start succeeds with err=0.
- Reset asserted mid-WRITE → all outputs 0 immediately; after release, start in IDLE begins a fresh transaction; start pulses while busy or in DONE are ignored.
- Instance with SETUP=GAP=RD=WR=1 → RMW gives rd in cycle 2, gap in cycle 3, wr in cycle 4, and done in cycle 5.
